// File: rtl/lsa_bus_ctl.sv
`default_nettype none
// ============================================================================
// Module   : lsa_bus_ctl
// Purpose  : Single-outstanding memory bus sequencer between the LSA CPU core
//            and lsa_mem. Turns a req/ack request into registered
//            mem_fetch/mem_oe/mem_we/mem_add/mem_in strobes with programmable
//            read-wait and write-hold timing, and captures read data.
// Revision : 1.0 - initial release
// ============================================================================
module lsa_bus_ctl #(
  parameter int unsigned RD_WAIT   = 1,
  parameter int unsigned WR_CYCLES = 1
) (
  input  logic        clock_in,
  input  logic        reset_in,
  input  logic        cpu_req,
  input  logic        cpu_rnw,
  input  logic        cpu_fetch,
  input  logic [15:0] cpu_add,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_ack,
  output logic        cpu_busy,
  output logic [15:0] cpu_rdata,
  output logic        mem_fetch,
  output logic        mem_oe,
  output logic        mem_we,
  output logic [15:0] mem_add,
  output logic [15:0] mem_in,
  input  logic [15:0] mem_rdata
);

  // Counter preload for a phase lasting 'cycles' clocks. Zero is treated as
  // one cycle; values above the 4-bit counter range saturate at 16 cycles.
  function automatic logic [3:0] load_val(input int unsigned cycles);
    if (cycles <= 32'd1) begin
      return 4'd0;
    end else if (cycles >= 32'd16) begin
      return 4'd15;
    end else begin
      return 4'(cycles - 32'd1);
    end
  endfunction

  localparam logic [3:0] c_rd_load = load_val(RD_WAIT);
  localparam logic [3:0] c_wr_load = load_val(WR_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_next_state;
  logic [3:0] r_cnt;
  logic [3:0] w_next_cnt;
  logic       r_fetch;
  logic       w_accept;
  logic       w_capture;
  logic       w_fetch_bit;

  // Next-state and wait-counter logic; also flags acceptance and read capture.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_accept     = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cpu_req) begin
          w_accept = 1'b1;
          if (cpu_rnw) begin
            w_next_state = ST_READ;
            w_next_cnt   = c_rd_load;
          end else begin
            w_next_state = ST_WRITE;
            w_next_cnt   = c_wr_load;
          end
        end
      end
      ST_READ: begin
        if (r_cnt == 4'd0) begin
          w_capture    = 1'b1;
          w_next_state = ST_DONE;
        end else begin
          w_next_cnt = r_cnt - 4'd1;
        end
      end
      ST_WRITE: begin
        if (r_cnt == 4'd0) begin
          w_next_state = ST_DONE;
        end else begin
          w_next_cnt = r_cnt - 4'd1;
        end
      end
      ST_DONE: begin
        // Request is deliberately ignored here; the CPU drops it during ack.
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
        w_next_cnt   = 4'd0;
      end
    endcase
  end

  // Fetch qualifier for the upcoming READ phase: fresh from the CPU on the
  // accepting edge, otherwise the value latched at acceptance.
  always_comb begin
    w_fetch_bit = r_fetch;
    if (w_accept) begin
      w_fetch_bit = cpu_fetch;
    end
  end

  // State register and wait counter.
  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  // Registered strobes decoded from the next state so they line up with it.
  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      mem_oe    <= 1'b0;
      mem_we    <= 1'b0;
      mem_fetch <= 1'b0;
      cpu_ack   <= 1'b0;
      cpu_busy  <= 1'b0;
    end else begin
      mem_oe    <= (w_next_state == ST_READ);
      mem_we    <= (w_next_state == ST_WRITE);
      mem_fetch <= (w_next_state == ST_READ) && w_fetch_bit;
      cpu_ack   <= (w_next_state == ST_DONE);
      cpu_busy  <= (w_next_state != ST_IDLE);
    end
  end

  // Address/data latches and read-data capture; CPU bus may change after accept.
  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      r_fetch   <= 1'b0;
      mem_add   <= 16'h0000;
      mem_in    <= 16'h0000;
      cpu_rdata <= 16'h0000;
    end else begin
      if (w_accept) begin
        r_fetch <= cpu_fetch;
        mem_add <= cpu_add;
        if (!cpu_rnw) begin
          mem_in <= cpu_wdata;
        end
      end
      if (w_capture) begin
        cpu_rdata <= mem_rdata;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lsa_bus_ctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsa_bus_ctl
// Purpose  : Self-checking bench for lsa_bus_ctl. Two instances (fast 1/1 and
//            slow 3/2 timing) each drive a small memory stub; results are
//            compared against an address-map reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsa_bus_ctl;

  localparam int RD_A = 1;
  localparam int WR_A = 1;
  localparam int RD_B = 3;
  localparam int WR_B = 2;

  typedef struct {
    int          lat;
    int          oe_n;
    int          we_n;
    int          fe_n;
    int          bad;
    int          ack_at;
    logic [15:0] rd;
  } obs_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc_cnt = 0;
  int   tests_run = 0;
  int   tests_failed = 0;

  logic        req_a = 1'b0, rnw_a = 1'b0, cfe_a = 1'b0;
  logic [15:0] add_a = '0, wd_a = '0;
  logic        ack_a, busy_a, fe_a, oe_a, we_a;
  logic [15:0] rd_a, madd_a, min_a, mrd_a;

  logic        req_b = 1'b0, rnw_b = 1'b0, cfe_b = 1'b0;
  logic [15:0] add_b = '0, wd_b = '0;
  logic        ack_b, busy_b, fe_b, oe_b, we_b;
  logic [15:0] rd_b, madd_b, min_b, mrd_b;

  // Memory stub: ROM at 0x0000-0x000F, RAM at 0x0100-0x010F, LED at 0xF100.
  logic [15:0] rom   [16];
  logic [15:0] ram_a [16];
  logic [15:0] ram_b [16];
  logic        led_a = 1'b0;
  logic        led_b = 1'b0;

  // Reference model: expected memory contents, LED state and cpu_rdata.
  logic [15:0] model_a [int];
  logic [15:0] model_b [int];
  logic        led_exp [2];
  logic [15:0] last_rd [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  lsa_bus_ctl #(.RD_WAIT(RD_A), .WR_CYCLES(WR_A)) dut_a (
    .clock_in(clk), .reset_in(rst_n), .cpu_req(req_a), .cpu_rnw(rnw_a),
    .cpu_fetch(cfe_a), .cpu_add(add_a), .cpu_wdata(wd_a), .cpu_ack(ack_a),
    .cpu_busy(busy_a), .cpu_rdata(rd_a), .mem_fetch(fe_a), .mem_oe(oe_a),
    .mem_we(we_a), .mem_add(madd_a), .mem_in(min_a), .mem_rdata(mrd_a)
  );

  lsa_bus_ctl #(.RD_WAIT(RD_B), .WR_CYCLES(WR_B)) dut_b (
    .clock_in(clk), .reset_in(rst_n), .cpu_req(req_b), .cpu_rnw(rnw_b),
    .cpu_fetch(cfe_b), .cpu_add(add_b), .cpu_wdata(wd_b), .cpu_ack(ack_b),
    .cpu_busy(busy_b), .cpu_rdata(rd_b), .mem_fetch(fe_b), .mem_oe(oe_b),
    .mem_we(we_b), .mem_add(madd_b), .mem_in(min_b), .mem_rdata(mrd_b)
  );

  always_comb begin
    if (madd_a[15:4] == 12'h010)      mrd_a = ram_a[madd_a[3:0]];
    else if (madd_a[15:4] == 12'h000) mrd_a = rom[madd_a[3:0]];
    else                              mrd_a = 16'hffff;
  end

  always_comb begin
    if (madd_b[15:4] == 12'h010)      mrd_b = ram_b[madd_b[3:0]];
    else if (madd_b[15:4] == 12'h000) mrd_b = rom[madd_b[3:0]];
    else                              mrd_b = 16'hffff;
  end

  always @(posedge clk) begin
    if (we_a) begin
      if (madd_a[15:4] == 12'h010) ram_a[madd_a[3:0]] <= min_a;
      if (madd_a == 16'hf100) led_a <= min_a[8];
    end
    if (we_b) begin
      if (madd_b[15:4] == 12'h010) ram_b[madd_b[3:0]] <= min_b;
      if (madd_b == 16'hf100) led_b <= min_b[8];
    end
  end

  function automatic logic [15:0] mread(input bit b, input logic [15:0] addr);
    int k;
    k = int'(addr);
    if (b) return model_b.exists(k) ? model_b[k] : 16'hffff;
    return model_a.exists(k) ? model_a[k] : 16'hffff;
  endfunction

  task automatic mwrite(input bit b, input logic [15:0] addr, input logic [15:0] data);
    if (addr >= 16'h0100 && addr <= 16'h010f) begin
      if (b) model_b[int'(addr)] = data;
      else   model_a[int'(addr)] = data;
    end
    if (addr == 16'hf100) led_exp[b] = data[8];
  endtask

  task automatic set_in(input bit b, input logic req, input logic rnw, input logic fetch,
                        input logic [15:0] add, input logic [15:0] wdata);
    if (b) begin
      req_b = req; rnw_b = rnw; cfe_b = fetch; add_b = add; wd_b = wdata;
    end else begin
      req_a = req; rnw_a = rnw; cfe_a = fetch; add_a = add; wd_a = wdata;
    end
  endtask

  task automatic peek(input bit b, output logic ack, output logic busy, output logic oe,
                      output logic we, output logic fe, output logic [15:0] madd,
                      output logic [15:0] min, output logic [15:0] rd);
    ack  = b ? ack_b  : ack_a;
    busy = b ? busy_b : busy_a;
    oe   = b ? oe_b   : oe_a;
    we   = b ? we_b   : we_a;
    fe   = b ? fe_b   : fe_a;
    madd = b ? madd_b : madd_a;
    min  = b ? min_b  : min_a;
    rd   = b ? rd_b   : rd_a;
  endtask

  // Runs one transaction starting just after a falling edge; gathers observations.
  task automatic drive(input bit b, input logic rnw, input logic fetch,
                       input logic [15:0] add, input logic [15:0] wdata, output obs_t o);
    logic s_ack, s_busy, s_oe, s_we, s_fe;
    logic [15:0] s_madd, s_min, s_rd;
    o.lat = -1; o.oe_n = 0; o.we_n = 0; o.fe_n = 0; o.bad = 0; o.ack_at = -1; o.rd = '0;
    set_in(b, 1'b1, rnw, fetch, add, wdata);
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      peek(b, s_ack, s_busy, s_oe, s_we, s_fe, s_madd, s_min, s_rd);
      if (cyc == 1) set_in(b, 1'b0, 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom));
      if (s_oe) o.oe_n++;
      if (s_we) o.we_n++;
      if (s_fe) o.fe_n++;
      if ((s_oe || s_we) && s_madd !== add) o.bad++;
      if (s_we && s_min !== wdata) o.bad++;
      if (s_busy !== 1'b1) o.bad++;
      if (s_ack === 1'b1) begin
        o.lat = cyc; o.rd = s_rd; o.ack_at = cyc_cnt;
        break;
      end
    end
    @(negedge clk);
    peek(b, s_ack, s_busy, s_oe, s_we, s_fe, s_madd, s_min, s_rd);
    if (s_busy !== 1'b0 || s_ack !== 1'b0 || s_oe !== 1'b0 || s_we !== 1'b0 || s_rd !== o.rd) o.bad++;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    tests_run++; if ({ack_a, busy_a, fe_a, oe_a, we_a, rd_a, madd_a, min_a} !== 53'd0) begin tests_failed++; $display("FAIL reset_a: got %0h expected 0", {ack_a, busy_a, fe_a, oe_a, we_a, rd_a, madd_a, min_a}); end
    tests_run++; if ({ack_b, busy_b, fe_b, oe_b, we_b, rd_b, madd_b, min_b} !== 53'd0) begin tests_failed++; $display("FAIL reset_b: got %0h expected 0", {ack_b, busy_b, fe_b, oe_b, we_b, rd_b, madd_b, min_b}); end
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++; if ({ack_a, busy_a, oe_a, we_a} !== 4'd0) begin tests_failed++; $display("FAIL idle_after_reset: got %0h expected 0", {ack_a, busy_a, oe_a, we_a}); end
  endtask

  task automatic test_fetch();
    obs_t o;
    drive(1'b0, 1'b1, 1'b1, 16'h0000, 16'h0000, o);
    tests_run++; if (o.lat !== RD_A + 1) begin tests_failed++; $display("FAIL fetch_latency: got %0d expected %0d", o.lat, RD_A + 1); end
    tests_run++; if (o.oe_n !== RD_A) begin tests_failed++; $display("FAIL fetch_oe_cycles: got %0d expected %0d", o.oe_n, RD_A); end
    tests_run++; if (o.fe_n !== RD_A) begin tests_failed++; $display("FAIL fetch_strobe_cycles: got %0d expected %0d", o.fe_n, RD_A); end
    tests_run++; if (o.bad !== 0) begin tests_failed++; $display("FAIL fetch_bus: got %0d errors expected 0", o.bad); end
    tests_run++; if (o.rd !== 16'hc001) begin tests_failed++; $display("FAIL fetch_rdata: got %0h expected c001", o.rd); end
    last_rd[0] = 16'hc001;
  endtask

  task automatic test_sequential();
    obs_t o1, o2;
    drive(1'b0, 1'b1, 1'b0, 16'h0002, 16'h0000, o1);
    drive(1'b0, 1'b1, 1'b0, 16'h0009, 16'h0000, o2);
    tests_run++; if (o1.rd !== 16'h97f1) begin tests_failed++; $display("FAIL seq_rdata1: got %0h expected 97f1", o1.rd); end
    tests_run++; if (o2.rd !== 16'hc0fa) begin tests_failed++; $display("FAIL seq_rdata2: got %0h expected c0fa", o2.rd); end
    tests_run++; if (o2.ack_at - o1.ack_at !== RD_A + 2) begin tests_failed++; $display("FAIL seq_spacing: got %0d expected %0d", o2.ack_at - o1.ack_at, RD_A + 2); end
    tests_run++; if (o1.fe_n + o2.fe_n + o1.bad + o2.bad !== 0) begin tests_failed++; $display("FAIL seq_bus: got %0d errors expected 0", o1.fe_n + o2.fe_n + o1.bad + o2.bad); end
    last_rd[0] = 16'hc0fa;
  endtask

  task automatic test_unmapped();
    obs_t o;
    drive(1'b0, 1'b1, 1'b0, 16'h1234, 16'h0000, o);
    tests_run++; if (o.rd !== 16'hffff) begin tests_failed++; $display("FAIL unmapped_rdata: got %0h expected ffff", o.rd); end
    last_rd[0] = 16'hffff;
  endtask

  task automatic test_led_write();
    obs_t o;
    drive(1'b0, 1'b0, 1'b1, 16'hf100, 16'h0100, o);
    mwrite(1'b0, 16'hf100, 16'h0100);
    tests_run++; if (o.lat !== WR_A + 1) begin tests_failed++; $display("FAIL led_latency: got %0d expected %0d", o.lat, WR_A + 1); end
    tests_run++; if (o.we_n !== WR_A || o.oe_n !== 0 || o.fe_n !== 0) begin tests_failed++; $display("FAIL led_strobes: got we=%0d oe=%0d fe=%0d expected we=%0d oe=0 fe=0", o.we_n, o.oe_n, o.fe_n, WR_A); end
    tests_run++; if (o.bad !== 0) begin tests_failed++; $display("FAIL led_bus: got %0d errors expected 0", o.bad); end
    tests_run++; if (led_a !== led_exp[0]) begin tests_failed++; $display("FAIL led_on: got %0b expected %0b", led_a, led_exp[0]); end
    tests_run++; if (o.rd !== last_rd[0]) begin tests_failed++; $display("FAIL led_rdata_kept: got %0h expected %0h", o.rd, last_rd[0]); end
    drive(1'b0, 1'b0, 1'b0, 16'hf100, 16'h0000, o);
    mwrite(1'b0, 16'hf100, 16'h0000);
    tests_run++; if (led_a !== led_exp[0]) begin tests_failed++; $display("FAIL led_off: got %0b expected %0b", led_a, led_exp[0]); end
  endtask

  task automatic test_slow_build();
    obs_t o;
    logic [15:0] wd;
    wd = 16'($urandom);
    drive(1'b1, 1'b1, 1'b0, 16'h0004, 16'h0000, o);
    tests_run++; if (o.lat !== RD_B + 1) begin tests_failed++; $display("FAIL slow_rd_latency: got %0d expected %0d", o.lat, RD_B + 1); end
    tests_run++; if (o.oe_n !== RD_B) begin tests_failed++; $display("FAIL slow_oe_cycles: got %0d expected %0d", o.oe_n, RD_B); end
    tests_run++; if (o.rd !== 16'h6889) begin tests_failed++; $display("FAIL slow_rdata: got %0h expected 6889", o.rd); end
    last_rd[1] = 16'h6889;
    drive(1'b1, 1'b0, 1'b0, 16'h0107, wd, o);
    mwrite(1'b1, 16'h0107, wd);
    tests_run++; if (o.lat !== WR_B + 1) begin tests_failed++; $display("FAIL slow_wr_latency: got %0d expected %0d", o.lat, WR_B + 1); end
    tests_run++; if (o.we_n !== WR_B || o.bad !== 0) begin tests_failed++; $display("FAIL slow_we: got we=%0d errors=%0d expected we=%0d errors=0", o.we_n, o.bad, WR_B); end
    drive(1'b1, 1'b1, 1'b0, 16'h0107, 16'h0000, o);
    tests_run++; if (o.rd !== mread(1'b1, 16'h0107)) begin tests_failed++; $display("FAIL slow_readback: got %0h expected %0h", o.rd, mread(1'b1, 16'h0107)); end
    last_rd[1] = mread(1'b1, 16'h0107);
  endtask

  task automatic test_random(input bit b, input int n);
    obs_t o;
    logic rnw, fetch;
    logic [15:0] add, wd, exp_rd;
    int rdc, wrc;
    rdc = b ? RD_B : RD_A;
    wrc = b ? WR_B : WR_A;
    for (int i = 0; i < n; i++) begin
      rnw   = 1'($urandom);
      fetch = 1'($urandom);
      wd    = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       add = {12'h000, 4'($urandom)};
        1:       add = {12'h010, 4'($urandom)};
        2:       add = 16'hf100;
        default: add = 16'($urandom);
      endcase
      exp_rd = rnw ? mread(b, add) : last_rd[b];
      drive(b, rnw, fetch, add, wd, o);
      if (!rnw) mwrite(b, add, wd);
      tests_run++; if (o.lat !== (rnw ? rdc : wrc) + 1) begin tests_failed++; $display("FAIL rand%0d_%0d_latency: got %0d expected %0d", b, i, o.lat, (rnw ? rdc : wrc) + 1); end
      tests_run++; if (o.oe_n !== (rnw ? rdc : 0) || o.we_n !== (rnw ? 0 : wrc)) begin tests_failed++; $display("FAIL rand%0d_%0d_strobes: got oe=%0d we=%0d", b, i, o.oe_n, o.we_n); end
      tests_run++; if (o.fe_n !== ((rnw && fetch) ? rdc : 0)) begin tests_failed++; $display("FAIL rand%0d_%0d_fetch: got %0d expected %0d", b, i, o.fe_n, (rnw && fetch) ? rdc : 0); end
      tests_run++; if (o.bad !== 0) begin tests_failed++; $display("FAIL rand%0d_%0d_bus: got %0d errors expected 0", b, i, o.bad); end
      tests_run++; if (o.rd !== exp_rd) begin tests_failed++; $display("FAIL rand%0d_%0d_rdata: got %0h expected %0h", b, i, o.rd, exp_rd); end
      last_rd[b] = exp_rd;
    end
    tests_run++; if ((b ? led_b : led_a) !== led_exp[b]) begin tests_failed++; $display("FAIL rand%0d_led: got %0b expected %0b", b, b ? led_b : led_a, led_exp[b]); end
  endtask

  task automatic test_held_req();
    int prev, nacks, bad;
    bit idle_seen;
    prev = -1; nacks = 0; bad = 0; idle_seen = 1'b0;
    set_in(1'b0, 1'b1, 1'b1, 1'b0, 16'h0009, 16'h0000);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (ack_a === 1'b1) begin
        if (prev >= 0 && i - prev != RD_A + 2) bad++;
        if (rd_a !== 16'hc0fa) bad++;
        prev = i;
        nacks++;
      end
    end
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 16'h0009, 16'h0000);
    for (int i = 0; i < 10 && !idle_seen; i++) begin
      @(negedge clk);
      if (busy_a === 1'b0 && ack_a === 1'b0) idle_seen = 1'b1;
    end
    last_rd[0] = 16'hc0fa;
    tests_run++; if (bad !== 0) begin tests_failed++; $display("FAIL held_spacing: got %0d errors expected 0", bad); end
    tests_run++; if (nacks !== 10) begin tests_failed++; $display("FAIL held_ack_count: got %0d expected 10", nacks); end
    tests_run++; if (idle_seen !== 1'b1) begin tests_failed++; $display("FAIL held_return_idle: got %0b expected 1", idle_seen); end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    int acks;
    drive(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, o);
    tests_run++; if (o.rd !== 16'hc001) begin tests_failed++; $display("FAIL pre_reset_rdata: got %0h expected c001", o.rd); end
    set_in(1'b0, 1'b1, 1'b1, 1'b1, 16'h0003, 16'h0000);
    @(negedge clk);
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 16'h0003, 16'h0000);
    tests_run++; if (oe_a !== 1'b1) begin tests_failed++; $display("FAIL mid_in_read: got oe=%0b expected 1", oe_a); end
    #2 rst_n = 1'b0;
    #1;
    tests_run++; if ({oe_a, fe_a, we_a, ack_a, busy_a, rd_a} !== 21'd0) begin tests_failed++; $display("FAIL mid_reset_outputs: got %0h expected 0", {oe_a, fe_a, we_a, ack_a, busy_a, rd_a}); end
    acks = 0;
    repeat (2) begin
      @(negedge clk);
      if (ack_a !== 1'b0) acks++;
    end
    tests_run++; if (acks !== 0) begin tests_failed++; $display("FAIL mid_reset_no_ack: got %0d acks expected 0", acks); end
    rst_n = 1'b1;
    last_rd[0] = 16'h0000;
    last_rd[1] = 16'h0000;
    drive(1'b0, 1'b1, 1'b0, 16'h0001, 16'h0000, o);
    tests_run++; if (o.lat !== RD_A + 1) begin tests_failed++; $display("FAIL post_reset_latency: got %0d expected %0d", o.lat, RD_A + 1); end
    tests_run++; if (o.rd !== 16'hc000) begin tests_failed++; $display("FAIL post_reset_rdata: got %0h expected c000", o.rd); end
    tests_run++; if (rd_b !== last_rd[1]) begin tests_failed++; $display("FAIL reset_clears_b: got %0h expected %0h", rd_b, last_rd[1]); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      rom[i]   = 16'($urandom);
      ram_a[i] = 16'($urandom);
      ram_b[i] = 16'($urandom);
    end
    rom[0] = 16'hc001; rom[1] = 16'hc000; rom[2] = 16'h97f1;
    rom[4] = 16'h6889; rom[9] = 16'hc0fa;
    for (int i = 0; i < 16; i++) begin
      model_a[i] = rom[i];
      model_b[i] = rom[i];
      model_a[256 + i] = ram_a[i];
      model_b[256 + i] = ram_b[i];
    end
    led_exp[0] = 1'b0; led_exp[1] = 1'b0;
    last_rd[0] = 16'h0000; last_rd[1] = 16'h0000;

    test_reset();
    test_fetch();
    test_sequential();
    test_unmapped();
    test_led_write();
    test_slow_build();
    test_random(1'b0, 20);
    test_random(1'b1, 12);
    test_held_req();
    test_reset_mid();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
